// File: rtl/register_file_onehot_if.sv
// Purpose : bundles the write-select/data, read address/data, debug and status
//           signals of the one-hot register file into a single port.
// Latency : n/a (wiring only); backpressure: none, every signal is level-based.
// Modports: master = pipeline/bench side (drives selects/addresses, sees data),
//           slave  = register file side.
interface register_file_onehot_if #(
  parameter int DATA_W = 32
);
  logic [31:0]       Register_num;   // one-hot write-select, bit i -> xi
  logic [DATA_W-1:0] WriteData;      // WB-stage write data
  logic [4:0]        ReadRegister1;  // rs1 address
  logic [4:0]        ReadRegister2;  // rs2 address
  logic [DATA_W-1:0] ReadData1;      // rs1 value
  logic [DATA_W-1:0] ReadData2;      // rs2 value
  logic [4:0]        DbgRegister;    // debug read address
  logic [DATA_W-1:0] DbgData;        // debug read value
  logic              onehot_err;     // sticky malformed-select flag
  logic [15:0]       wr_count;       // saturating committed-write counter

  modport master (
    output Register_num, WriteData, ReadRegister1, ReadRegister2, DbgRegister,
    input  ReadData1, ReadData2, DbgData, onehot_err, wr_count
  );

  modport slave (
    input  Register_num, WriteData, ReadRegister1, ReadRegister2, DbgRegister,
    output ReadData1, ReadData2, DbgData, onehot_err, wr_count
  );
endinterface

// File: rtl/register_file_onehot.sv
// Purpose : 32x32 RISC-V integer register file written through a one-hot select,
//           with two ID read ports, a debug read port, a sticky malformed-select
//           flag and a saturating committed-write counter.
// Latency : writes commit on the rising edge (visible after it); reads are
//           combinational. Backpressure: none, a write is accepted every cycle.
// Ports   : clk, rst (async, active-high); rf (register_file_onehot_if.slave)
//           carrying Register_num/WriteData, ReadRegister1/2 -> ReadData1/2,
//           DbgRegister -> DbgData, onehot_err, wr_count.
// Option  : define REGFILE_BYPASS_EN for same-cycle write-through on all read
//           ports; undefined, reads return stored values only.
module register_file_onehot #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input logic                  clk,
  input logic                  rst,
  register_file_onehot_if.slave rf
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [IDX_W-1:0]  wr_idx;
  logic              sel_any;
  logic              sel_single;
  logic              sel_multi;
  logic              wr_valid;

  // OR-encoder: each index bit is the OR of all select bits whose position has
  // that bit set. Only meaningful when exactly one select bit is high.
  always_comb begin
    wr_idx = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rf.Register_num[i]) wr_idx = wr_idx | IDX_W'(i);
    end
  end

  // A power of two has no bits in common with itself minus one.
  assign sel_any    = (rf.Register_num != '0);
  assign sel_single = sel_any && ((rf.Register_num & (rf.Register_num - 32'd1)) == '0);
  assign sel_multi  = sel_any && !sel_single;
  // A lone bit 0 is a well-formed select that simply targets the zero register.
  assign wr_valid   = sel_single && (wr_idx != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_valid) begin
      regs[wr_idx] <= rf.WriteData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf.onehot_err <= 1'b0;
      rf.wr_count   <= '0;
    end else begin
      if (sel_multi) rf.onehot_err <= 1'b1;
      if (wr_valid && rf.wr_count != 16'hFFFF) rf.wr_count <= rf.wr_count + 16'd1;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [IDX_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = regs[addr];
`ifdef REGFILE_BYPASS_EN
    if (wr_valid && addr == wr_idx) val = rf.WriteData;
`endif
    if (addr == '0) val = '0;
    return val;
  endfunction

  assign rf.ReadData1 = read_port(rf.ReadRegister1);
  assign rf.ReadData2 = read_port(rf.ReadRegister2);
  assign rf.DbgData   = read_port(rf.DbgRegister);

endmodule

// File: tb/tb_register_file_onehot.sv
// Purpose : directed, self-checking bench for register_file_onehot.
// Latency : inputs driven 1 ns after a rising edge, outputs sampled there too.
// Backpressure: n/a.
module tb_register_file_onehot;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;
  logic [31:0] last_val [32];
  logic [31:0] exp31;

  register_file_onehot_if #(.DATA_W(32)) rf_if ();

  register_file_onehot dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  // One write cycle, leaving the select idle afterwards.
  task automatic wr(input logic [31:0] sel, input logic [31:0] data);
    rf_if.Register_num = sel;
    rf_if.WriteData    = data;
    edge_step();
    rf_if.Register_num = '0;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst = 1'b1;
    rf_if.Register_num  = '0;
    rf_if.WriteData     = '0;
    rf_if.ReadRegister1 = 5'd5;
    rf_if.ReadRegister2 = 5'd9;
    rf_if.DbgRegister   = 5'd5;
    #12;
    check("reset_rd1", rf_if.ReadData1, 32'h0);
    check("reset_cnt", {16'h0, rf_if.wr_count}, 32'h0);
    rst = 1'b0;
    edge_step();

    // 1: populate x5/x9 and set the error flag, then reset between edges.
    wr(32'h0000_0020, 32'h0000_1111);
    wr(32'h0000_0200, 32'h0000_2222);
    wr(32'h0000_0003, 32'hFFFF_FFFF);
    check("pre_rst_x5", rf_if.ReadData1, 32'h0000_1111);
    check("pre_rst_x9", rf_if.ReadData2, 32'h0000_2222);
    check("pre_rst_err", {31'h0, rf_if.onehot_err}, 32'h1);
    check("pre_rst_cnt", {16'h0, rf_if.wr_count}, 32'd2);
    #2 rst = 1'b1;
    #1;
    check("arst_rd1", rf_if.ReadData1, 32'h0);
    check("arst_rd2", rf_if.ReadData2, 32'h0);
    check("arst_dbg", rf_if.DbgData, 32'h0);
    check("arst_err", {31'h0, rf_if.onehot_err}, 32'h0);
    check("arst_cnt", {16'h0, rf_if.wr_count}, 32'h0);
    #2 rst = 1'b0;
    edge_step();

    // 2: single valid write to x5.
    wr(32'h0000_0020, 32'hDEAD_BEEF);
    check("wr_x5", rf_if.ReadData1, 32'hDEAD_BEEF);
    check("wr_x5_cnt", {16'h0, rf_if.wr_count}, 32'd1);

    // 3: write aimed at x0 is dropped, not counted, not an error.
    rf_if.ReadRegister2 = 5'd0;
    rf_if.DbgRegister   = 5'd0;
    wr(32'h0000_0001, 32'h1234_5678);
    check("x0_rd2", rf_if.ReadData2, 32'h0);
    check("x0_dbg", rf_if.DbgData, 32'h0);
    check("x0_cnt", {16'h0, rf_if.wr_count}, 32'd1);
    check("x0_err", {31'h0, rf_if.onehot_err}, 32'h0);
    wr(32'h0, 32'hCAFE_CAFE);
    check("idle_cnt", {16'h0, rf_if.wr_count}, 32'd1);

    // 4: malformed select leaves x8/x9 alone and latches the error flag.
    wr(32'h0000_0100, 32'h0000_0088);
    wr(32'h0000_0200, 32'h0000_0099);
    rf_if.ReadRegister1 = 5'd8;
    rf_if.ReadRegister2 = 5'd9;
    wr(32'h0000_0300, 32'hFFFF_FFFF);
    check("multi_x8", rf_if.ReadData1, 32'h0000_0088);
    check("multi_x9", rf_if.ReadData2, 32'h0000_0099);
    check("multi_err", {31'h0, rf_if.onehot_err}, 32'h1);
    check("multi_cnt", {16'h0, rf_if.wr_count}, 32'd3);
    rf_if.DbgRegister = 5'd10;
    wr(32'h0000_0400, 32'h0000_1010);
    check("sticky_err", {31'h0, rf_if.onehot_err}, 32'h1);
    check("after_x10", rf_if.DbgData, 32'h0000_1010);
    check("after_cnt", {16'h0, rf_if.wr_count}, 32'd4);

    // 5: same-cycle read of the register being written.
    wr(32'h8000_0000, 32'h3131_3131);
    rf_if.ReadRegister1 = 5'd31;
    rf_if.ReadRegister2 = 5'd31;
    rf_if.DbgRegister   = 5'd31;
    rf_if.Register_num  = 32'h8000_0001;
    rf_if.WriteData     = 32'h5555_5555;
    #1;
    check("malformed_nobyp", rf_if.ReadData1, 32'h3131_3131);
    rf_if.Register_num = 32'h8000_0000;
    rf_if.WriteData    = 32'hA5A5_A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp31 = 32'hA5A5_A5A5;
`else
    exp31 = 32'h3131_3131;
`endif
    check("same_cyc_rd1", rf_if.ReadData1, exp31);
    check("same_cyc_rd2", rf_if.ReadData2, exp31);
    check("same_cyc_dbg", rf_if.DbgData, exp31);
    edge_step();
    rf_if.Register_num = '0;
    check("post_edge_rd1", rf_if.ReadData1, 32'hA5A5_A5A5);
    check("post_edge_rd2", rf_if.ReadData2, 32'hA5A5_A5A5);
    check("post_edge_cnt", {16'h0, rf_if.wr_count}, 32'd6);

    // 6: long rotation of valid writes; counter must saturate, not wrap.
    for (int r = 0; r < 32; r++) last_val[r] = 32'h0;
    for (int k = 0; k < 65540; k++) begin
      int r;
      logic [31:0] d;
      r = (k % 31) + 1;
      d = 32'h5A00_0000 + 32'(k);
      last_val[r] = d;
      rf_if.Register_num = 32'h1 << r;
      rf_if.WriteData    = d;
      edge_step();
      if (k == 65527) check("cnt_fffe", {16'h0, rf_if.wr_count}, 32'h0000_FFFE);
      if (k == 65528) check("cnt_ffff", {16'h0, rf_if.wr_count}, 32'h0000_FFFF);
    end
    rf_if.Register_num = '0;
    edge_step();
    check("cnt_sat", {16'h0, rf_if.wr_count}, 32'h0000_FFFF);
    check("err_kept", {31'h0, rf_if.onehot_err}, 32'h1);
    for (int r = 0; r < 32; r++) begin
      rf_if.DbgRegister = 5'(r);
      #1;
      check($sformatf("dbg_x%0d", r), rf_if.DbgData, last_val[r]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
